sample_frame_writer: RTL and testbench

//  Upstream stage of the sample memory. Accepts a stream of audio samples over a

---
 rtl/sample_frame_writer_if.sv | 28 ++
 rtl/sample_frame_writer.sv | 97 +++++++++
 tb/tb_sample_frame_writer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sample_frame_writer_if.sv
// Sample stream, memory write port and frame hand-off signals of sample_frame_writer.
// master drives samples and releases; slave is the writer.
interface sample_frame_writer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_LENGTH = 14,
    parameter int OVF_WIDTH   = 16
);
    logic                   s_valid;
    logic [DATA_WIDTH-1:0]  s_data;
    logic                   s_ready;
    logic                   we;
    logic [ADDR_LENGTH-1:0] wraddr;
    logic [DATA_WIDTH-1:0]  wrdata;
    logic                   frame_valid;
    logic                   frame_bank;
    logic                   frame_release;
    logic [OVF_WIDTH-1:0]   overflow_cnt;

    modport master (
        output s_valid, s_data, frame_release,
        input  s_ready, we, wraddr, wrdata, frame_valid, frame_bank, overflow_cnt
    );

    modport slave (
        input  s_valid, s_data, frame_release,
        output s_ready, we, wraddr, wrdata, frame_valid, frame_bank, overflow_cnt
    );
endinterface

// File: rtl/sample_frame_writer.sv
// Ping-pong sample writer: streams samples into two memory banks (address MSB = bank)
// and hands each completed bank to the reader until it is released.
module sample_frame_writer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_LENGTH    = 14,
    parameter int DROP_WHEN_FULL = 0,
    parameter int OVF_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sample_frame_writer_if.slave bus
);
    localparam int IDX_W = ADDR_LENGTH - 1;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    function automatic logic [OVF_WIDTH-1:0] sat_inc(input logic [OVF_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                          wr_bank;
    logic [IDX_W-1:0]              wr_idx;
    logic [1:0]                    full;
    logic [1:0]                    full_nxt;
    logic                          oldest;
    logic                          bank_busy;
    logic                          rdy_p0;
    logic                          vld_p0;
    logic                          drop_p0;
    logic                          last_p0;
    logic                          rel_ok;

    logic                          vld_p1;
    logic [ADDR_LENGTH-1:0]        wraddr_p1;
    logic signed [DATA_WIDTH-1:0]  wrdata_p1;
    logic [OVF_WIDTH-1:0]          ovf_cnt;

    // Stage p0: handshake, bank bookkeeping and release arbitration
    always_comb begin
        bank_busy = full[wr_bank];
        rdy_p0    = !reset && ((DROP_WHEN_FULL != 0) || !bank_busy);
        vld_p0    = bus.s_valid && rdy_p0 && !bank_busy;
        drop_p0   = (DROP_WHEN_FULL != 0) && bus.s_valid && !reset && bank_busy;
        last_p0   = vld_p0 && (wr_idx == IDX_LAST);
        rel_ok    = bus.frame_release && (|full);
        full_nxt  = full;
        // The releasing bank is always full and the completing one never is,
        // so both updates can apply in the same cycle without conflict.
        if (rel_ok)
            full_nxt[oldest] = 1'b0;
        if (last_p0)
            full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            full    <= '0;
            oldest  <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            full <= full_nxt;
            if (rel_ok)
                oldest <= ~oldest;
            if (vld_p0) begin
                wr_idx <= wr_idx + 1'b1;
                if (last_p0)
                    wr_bank <= ~wr_bank;
            end
            if (drop_p0)
                ovf_cnt <= sat_inc(ovf_cnt);
        end
    end

    // Stage p1: registered memory write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            wraddr_p1 <= '0;
            wrdata_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                wraddr_p1 <= {wr_bank, wr_idx};
                wrdata_p1 <= $signed(bus.s_data);
            end
        end
    end

    assign bus.s_ready      = rdy_p0;
    assign bus.we           = vld_p1;
    assign bus.wraddr       = wraddr_p1;
    assign bus.wrdata       = $unsigned(wrdata_p1);
    assign bus.frame_valid  = |full;
    assign bus.frame_bank   = oldest;
    assign bus.overflow_cnt = ovf_cnt;
endmodule

// File: tb/tb_sample_frame_writer.sv
// Bench for sample_frame_writer: a stall-mode and a drop-mode instance share one stimulus
// stream and are compared each cycle against a frame-count model plus literal expectations.
module tb_sample_frame_writer;
    localparam int DW = 32;
    localparam int AL = 4;
    localparam int BANK = 8;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          frame_release;

    int checks = 0;
    int errors = 0;

    sample_frame_writer_if #(.DATA_WIDTH(DW), .ADDR_LENGTH(AL), .OVF_WIDTH(16)) if0 ();
    sample_frame_writer_if #(.DATA_WIDTH(DW), .ADDR_LENGTH(AL), .OVF_WIDTH(3))  if1 ();

    assign if0.s_valid = s_valid;
    assign if0.s_data = s_data;
    assign if0.frame_release = frame_release;
    assign if1.s_valid = s_valid;
    assign if1.s_data = s_data;
    assign if1.frame_release = frame_release;

    sample_frame_writer #(.DATA_WIDTH(DW), .ADDR_LENGTH(AL), .DROP_WHEN_FULL(0), .OVF_WIDTH(16))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    sample_frame_writer #(.DATA_WIDTH(DW), .ADDR_LENGTH(AL), .DROP_WHEN_FULL(1), .OVF_WIDTH(3))
        dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state is just samples accepted, frames released and samples dropped.
    int          acc [2];
    int          rel [2];
    int          ovf [2];
    logic        e_we [2];
    logic [3:0]  e_addr [2];
    logic [31:0] e_data [2];

    function automatic int pend_of(input int k);
        return acc[k] / BANK - rel[k];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                acc[k] <= 0; rel[k] <= 0; ovf[k] <= 0;
                e_we[k] <= 1'b0; e_addr[k] <= '0; e_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                e_we[k] <= s_valid && (pend_of(k) < 2);
                if (s_valid && (pend_of(k) < 2)) begin
                    e_addr[k] <= 4'(acc[k] % (2 * BANK));
                    e_data[k] <= s_data;
                    acc[k] <= acc[k] + 1;
                end
                if (k == 1 && s_valid && pend_of(k) == 2 && ovf[k] < 7)
                    ovf[k] <= ovf[k] + 1;
                if (frame_release && pend_of(k) > 0)
                    rel[k] <= rel[k] + 1;
            end
        end
    end

    task automatic cmp(input int k, input logic rdy, input logic we, input logic [3:0] addr,
                       input logic [31:0] data, input logic fv, input logic fb,
                       input logic [15:0] oc);
        chk($sformatf("dut%0d s_ready", k), 32'(rdy), 32'(!reset && (k == 1 || pend_of(k) < 2)));
        chk($sformatf("dut%0d we", k), 32'(we), 32'(e_we[k]));
        if (e_we[k] || reset) begin
            chk($sformatf("dut%0d wraddr", k), 32'(addr), 32'(e_addr[k]));
            chk($sformatf("dut%0d wrdata", k), data, e_data[k]);
        end
        chk($sformatf("dut%0d frame_valid", k), 32'(fv), 32'(pend_of(k) > 0));
        chk($sformatf("dut%0d frame_bank", k), 32'(fb), 32'(rel[k] % 2));
        chk($sformatf("dut%0d overflow_cnt", k), 32'(oc), 32'(ovf[k]));
    endtask

    always @(negedge clk) begin
        cmp(0, if0.s_ready, if0.we, if0.wraddr, if0.wrdata, if0.frame_valid, if0.frame_bank,
            if0.overflow_cnt);
        cmp(1, if1.s_ready, if1.we, if1.wraddr, if1.wrdata, if1.frame_valid, if1.frame_bank,
            16'(if1.overflow_cnt));
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        s_valid = v;
        s_data = d;
        frame_release = r;
        @(posedge clk);
        #1;
    endtask

    task automatic lit_port(input string tag, input logic w, input logic [3:0] a, input logic [31:0] d);
        chk({tag, " dut0 we"}, 32'(if0.we), 32'(w));
        chk({tag, " dut0 wraddr"}, 32'(if0.wraddr), 32'(a));
        chk({tag, " dut0 wrdata"}, if0.wrdata, d);
        chk({tag, " dut1 wraddr"}, 32'(if1.wraddr), 32'(a));
    endtask

    initial begin
        reset = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        frame_release = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset s_ready", 32'(if0.s_ready), 32'd0);
        chk("reset we", 32'(if0.we), 32'd0);
        reset = 1'b0;
        #1;
        chk("post-reset s_ready", 32'(if0.s_ready), 32'd1);

        // First bank: 0x100..0x107 at wraddr 0..7
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + i, 1'b0);
        lit_port("bank0 last", 1'b1, 4'd7, 32'h107);
        chk("bank0 frame_valid", 32'(if0.frame_valid), 32'd1);
        chk("bank0 frame_bank", 32'(if0.frame_bank), 32'd0);

        // Second bank then stall (mode 0) / drop (mode 1)
        for (int i = 8; i < 16; i++) cyc(1'b1, 32'h100 + i, 1'b0);
        lit_port("bank1 last", 1'b1, 4'd15, 32'h10F);
        s_valid = 1'b1;
        s_data = 32'h110;
        #1;
        chk("stall dut0 s_ready", 32'(if0.s_ready), 32'd0);
        chk("drop dut1 s_ready", 32'(if1.s_ready), 32'd1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h110 + i, 1'b0);
        chk("stall dut0 we", 32'(if0.we), 32'd0);
        chk("drop dut1 we", 32'(if1.we), 32'd0);
        chk("drop dut1 overflow 5", 32'(if1.overflow_cnt), 32'd5);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h115 + i, 1'b0);
        chk("drop dut1 overflow saturated", 32'(if1.overflow_cnt), 32'd7);
        chk("drop dut1 s_ready held", 32'(if1.s_ready), 32'd1);

        // Release both banks from the stall
        cyc(1'b0, 32'h0, 1'b1);
        chk("rel1 frame_bank", 32'(if0.frame_bank), 32'd1);
        chk("rel1 dut0 s_ready", 32'(if0.s_ready), 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("rel2 frame_valid", 32'(if0.frame_valid), 32'd0);
        cyc(1'b1, 32'h200, 1'b0);
        lit_port("after release", 1'b1, 4'd0, 32'h200);

        // Release of bank 0 coincides with completion of bank 1
        for (int i = 1; i < 8; i++) cyc(1'b1, 32'h200 + i, 1'b0);
        for (int i = 8; i < 15; i++) cyc(1'b1, 32'h200 + i, 1'b0);
        cyc(1'b1, 32'h20F, 1'b1);
        chk("simul frame_valid", 32'(if0.frame_valid), 32'd1);
        chk("simul frame_bank", 32'(if0.frame_bank), 32'd1);
        chk("simul dut0 s_ready", 32'(if0.s_ready), 32'd1);
        lit_port("simul last", 1'b1, 4'd15, 32'h20F);
        cyc(1'b1, 32'h210, 1'b0);
        lit_port("simul resume", 1'b1, 4'd0, 32'h210);

        // Partial bank 1, then reset mid-frame
        for (int i = 1; i < 8; i++) cyc(1'b1, 32'h210 + i, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + i, 1'b0);
        lit_port("partial", 1'b1, 4'd10, 32'h302);
        s_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        lit_port("async reset", 1'b0, 4'd0, 32'h0);
        chk("async reset frame_valid", 32'(if0.frame_valid), 32'd0);
        chk("async reset dut0 s_ready", 32'(if0.s_ready), 32'd0);
        chk("async reset dut1 s_ready", 32'(if1.s_ready), 32'd0);
        chk("async reset dut1 overflow", 32'(if1.overflow_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, 32'h400, 1'b0);
        lit_port("restart", 1'b1, 4'd0, 32'h400);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
